// File: rtl/screen_pkg.sv
// Shared screen-grid definitions: grid size, cell index type, direction codes
// and the wrap-around step helpers used by the cursor logic.
package screen;

    localparam int unsigned GRID_N = 9;

    typedef logic [3:0] cell_idx;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    function automatic cell_idx wrap_inc(cell_idx v);
        return (v == cell_idx'(GRID_N - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic cell_idx wrap_dec(cell_idx v);
        return (v == '0) ? cell_idx'(GRID_N - 1) : v - 1'b1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw, asynchronous push button.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            btn  <= 1'b0;
        end else begin
            meta <= btn_raw;
            btn  <= meta;
        end
    end

endmodule

// File: rtl/cursor_controller.sv
// Sudoku cursor: synchronized direction buttons with hold-to-repeat, wrap-around
// row/col stepping and a frame-locked blink flag for the highlight.
module cursor_controller
    import screen::*;
#(
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6,
    parameter int unsigned BLINK_FRAMES = 20
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    btn_up,
    input  logic    btn_down,
    input  logic    btn_left,
    input  logic    btn_right,
    input  logic    frame_tick,
    output cell_idx row,
    output cell_idx col,
    output logic    cursor_visible,
    output logic    moved
);

    localparam int unsigned MAX_DR  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned MAX_ALL = (MAX_DR > BLINK_FRAMES) ? MAX_DR : BLINK_FRAMES;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_t;

    logic up_s, down_s, left_s, right_s;

    btn_sync u_sync_up    (.clk(clk), .rst(rst), .btn_raw(btn_up),    .btn(up_s));
    btn_sync u_sync_down  (.clk(clk), .rst(rst), .btn_raw(btn_down),  .btn(down_s));
    btn_sync u_sync_left  (.clk(clk), .rst(rst), .btn_raw(btn_left),  .btn(left_s));
    btn_sync u_sync_right (.clk(clk), .rst(rst), .btn_raw(btn_right), .btn(right_s));

    state_t           state_q, state_d;
    dir_t             cur_dir_q, cur_dir_d;
    dir_t             dir;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] fcnt_last;
    cell_idx          row_q, row_d, col_q, col_d;
    logic             vis_q, vis_d;
    logic             moved_q;
    logic             move;

    always_comb begin
        if (up_s)         dir = DIR_UP;
        else if (down_s)  dir = DIR_DOWN;
        else if (left_s)  dir = DIR_LEFT;
        else if (right_s) dir = DIR_RIGHT;
        else              dir = DIR_NONE;
    end

    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        fcnt_d    = fcnt_q;
        move      = 1'b0;
        fcnt_last = (state_q == StDelay) ? DELAY_LAST : RATE_LAST;

        unique case (state_q)
            StIdle: begin
                if (dir != DIR_NONE) begin
                    move      = 1'b1;
                    cur_dir_d = dir;
                    fcnt_d    = '0;
                    state_d   = StDelay;
                end
            end
            StDelay, StRepeat: begin
                if (dir == DIR_NONE) begin
                    state_d = StIdle;
                    fcnt_d  = '0;
                end else if (dir != cur_dir_q) begin
                    // A different button takes over: behaves exactly like a fresh press.
                    move      = 1'b1;
                    cur_dir_d = dir;
                    fcnt_d    = '0;
                    state_d   = StDelay;
                end else if (frame_tick) begin
                    if (fcnt_q == fcnt_last) begin
                        move    = 1'b1;
                        fcnt_d  = '0;
                        state_d = StRepeat;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (move) begin
            case (dir)
                DIR_UP:    row_d = wrap_dec(row_q);
                DIR_DOWN:  row_d = wrap_inc(row_q);
                DIR_LEFT:  col_d = wrap_dec(col_q);
                DIR_RIGHT: col_d = wrap_inc(col_q);
                default:   ;
            endcase
        end
    end

    // A move restarts the blink phase and takes priority over a coinciding wrap.
    always_comb begin
        bcnt_d = bcnt_q;
        vis_d  = vis_q;
        if (move) begin
            bcnt_d = '0;
            vis_d  = 1'b1;
        end else if (frame_tick) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d = '0;
                vis_d  = ~vis_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cur_dir_q <= DIR_NONE;
            fcnt_q    <= '0;
            bcnt_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            vis_q     <= 1'b1;
            moved_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            fcnt_q    <= fcnt_d;
            bcnt_q    <= bcnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            vis_q     <= vis_d;
            moved_q   <= move;
        end
    end

    assign row            = row_q;
    assign col            = col_q;
    assign cursor_visible = vis_q;
    assign moved          = moved_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Randomized bench for cursor_controller: a hold-time reference model predicts each
// move, a scoreboard queue holds it, and a negedge monitor checks it against the DUT.
module tb_cursor_controller;

    localparam int RD = 30;
    localparam int RR = 6;
    localparam int BF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] row, col;
    logic       cursor_visible, moved;

    cursor_controller #(
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .frame_tick    (frame_tick),
        .row           (row),
        .col           (col),
        .cursor_visible(cursor_visible),
        .moved         (moved)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int row;
        int col;
    } exp_t;
    exp_t q[$];

    // Reference model: a move happens on a new press and on the held tick counts
    // RD, RD+RR, RD+2RR, ...; visibility is the parity of (ticks since last move) / BF.
    logic [3:0] d1 = '0, d2 = '0;   // raw buttons delayed through the 2-cycle sync
    int hold = 0;
    int held = 0;
    int m_row = 0, m_col = 0;
    int since = 0;
    int dir_m;
    bit mv;
    logic exp_vis = 1'b1;

    function automatic int prio(logic [3:0] b);
        if (b[3]) return 1;
        if (b[2]) return 2;
        if (b[1]) return 3;
        if (b[0]) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            d1 = '0; d2 = '0; hold = 0; held = 0;
            m_row = 0; m_col = 0; since = 0;
        end else begin
            dir_m = prio(d2);
            mv = 1'b0;
            if (dir_m == 0) begin
                hold = 0;
            end else if (dir_m != hold) begin
                hold = dir_m;
                held = 0;
                mv = 1'b1;
            end else if (frame_tick) begin
                held++;
                if (held >= RD && (held - RD) % RR == 0) mv = 1'b1;
            end
            if (mv) begin
                case (dir_m)
                    1: m_row = (m_row + 8) % 9;
                    2: m_row = (m_row + 1) % 9;
                    3: m_col = (m_col + 8) % 9;
                    default: m_col = (m_col + 1) % 9;
                endcase
                q.push_back('{cyc: cyc, row: m_row, col: m_col});
                since = 0;
            end else if (frame_tick) begin
                since++;
            end
            d2 = d1;
            d1 = {btn_up, btn_down, btn_left, btn_right};
        end
        exp_vis = ((since / BF) % 2) == 0;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        check("visible", int'(cursor_visible), int'(exp_vis));
        check("row_track", int'(row), m_row);
        check("col_track", int'(col), m_col);
        if (moved === 1'b1) begin
            if (q.size() == 0) begin
                check("moved_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                check("move_cycle", cyc, e.cyc);
                check("move_row", int'(row), e.row);
                check("move_col", int'(col), e.col);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("moved_missing", 0, 1);
        end
    end

    // Frame ticks arrive at random spacing, averaging one per four clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1 frame_tick = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic set_btn(input logic [3:0] b);
        @(posedge clk);
        #1 {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic wait_frames(input int k);
        for (int i = 0; i < k; i++) begin
            do @(posedge clk); while (!frame_tick);
        end
    endtask

    task automatic pulse_rst(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_row", int'(row), 0);
        check("reset_col", int'(col), 0);
        check("reset_visible", int'(cursor_visible), 1);
        check("reset_moved", int'(moved), 0);
        #1 rst = 1'b0;

        wait_frames(100);                        // idle blink
        set_btn(4'b1000); wait_frames(5);        // tap up: 0 -> 8
        set_btn(4'b0000); wait_frames(3);
        set_btn(4'b0001); wait_frames(80);       // hold right through a col wrap
        set_btn(4'b0000); wait_frames(3);
        set_btn(4'b1010); wait_frames(40);       // up+left: only row moves
        set_btn(4'b0010); wait_frames(40);       // left takes over
        set_btn(4'b0000); wait_frames(25);       // let blink go dark
        set_btn(4'b0100); wait_frames(2);        // tap down restores visibility
        set_btn(4'b0000); wait_frames(2);
        set_btn(4'b0001); wait_frames(40);       // reset in REPEAT with button held
        pulse_rst(2);
        wait_frames(35);
        set_btn(4'b0000); wait_frames(3);

        for (int i = 0; i < 60; i++) begin
            set_btn(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
            end else begin
                wait_frames($urandom_range(0, 45));
            end
            if ($urandom_range(0, 19) == 0) pulse_rst($urandom_range(1, 3));
        end
        set_btn(4'b0000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
